// File: rtl/tlb_cmd_unit_if.sv
// CP0 <-> TLB command and result bundle.
// master: the CP0/WB side that issues TLBWI/TLBR/TLBP and latches results.
// slave:  the TLB command unit.
interface tlb_cmd_unit_if;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic        cmd_done;
    logic [31:0] cp0_index;
    logic [31:0] cp0_entryhi;
    logic [31:0] cp0_entrylo0;
    logic [31:0] cp0_entrylo1;
    logic        is_TLBR;
    logic [77:0] TLB_rdata;
    logic        is_TLBP;
    logic        index_write_p;
    logic [3:0]  index_write_index;

    modport master (
        output cmd_valid, cmd_op, cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1,
        input  cmd_ready, cmd_done, is_TLBR, TLB_rdata, is_TLBP, index_write_p, index_write_index
    );

    modport slave (
        input  cmd_valid, cmd_op, cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1,
        output cmd_ready, cmd_done, is_TLBR, TLB_rdata, is_TLBP, index_write_p, index_write_index
    );
endinterface

// File: rtl/tlb_cmd_unit.sv
// tlb_cmd_unit: fully associative MIPS TLB (TLBNUM entries, default 16).
// Executes TLBWI / TLBR / TLBP commands from WB through a small FSM and
// returns the results CP0 latches. Two combinational lookup ports serve
// instruction fetch (s0) and data access (s1).
// Optional build macro TLB_TLBWR_EN adds a free-running random register,
// op 00 = TLBWR and the random_index output.
module tlb_cmd_unit #(
    parameter int TLBNUM = 16
) (
    input  logic          cp0_clk,
    input  logic          reset,
    tlb_cmd_unit_if.slave bus,
    input  logic [18:0]   s0_vpn2,
    input  logic          s0_odd,
    input  logic [7:0]    s0_asid,
    output logic          s0_found,
    output logic [19:0]   s0_pfn,
    output logic [2:0]    s0_c,
    output logic          s0_d,
    output logic          s0_v,
    input  logic [18:0]   s1_vpn2,
    input  logic          s1_odd,
    input  logic [7:0]    s1_asid,
    output logic          s1_found,
    output logic [19:0]   s1_pfn,
    output logic [2:0]    s1_c,
    output logic          s1_d,
    output logic          s1_v
`ifdef TLB_TLBWR_EN
    ,
    output logic [3:0]    random_index
`endif
);

    localparam int IW = (TLBNUM > 1) ? $clog2(TLBNUM) : 1;
    localparam logic [4:0] NUM5 = 5'(TLBNUM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROBE  = 2'd1,
        P_RESP = 2'd2,
        R_RESP = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Entry storage, one array per field
    logic [18:0]       vpn2_q [TLBNUM];
    logic [7:0]        asid_q [TLBNUM];
    logic [TLBNUM-1:0] g_q;
    logic [19:0]       pfn0_q [TLBNUM];
    logic [2:0]        c0_q   [TLBNUM];
    logic [TLBNUM-1:0] d0_q;
    logic [TLBNUM-1:0] v0_q;
    logic [19:0]       pfn1_q [TLBNUM];
    logic [2:0]        c1_q   [TLBNUM];
    logic [TLBNUM-1:0] d1_q;
    logic [TLBNUM-1:0] v1_q;

    // Command / result state
    logic [18:0]       key_vpn2_q;
    logic [7:0]        key_asid_q;
    logic [TLBNUM-1:0] match_q;
    logic [TLBNUM-1:0] probe_hit;
    logic [77:0]       rdata_q;
    logic              wr_done_q;
    logic              wp_hold_q;
    logic [3:0]        widx_hold_q;

    logic              is_idle;
    logic              accept_wi;
    logic              accept_wr;
    logic              accept_r;
    logic              accept_p;
    logic              wr_en;
    logic              wr_ok;
    logic [3:0]        wr_idx;
    logic [IW-1:0]     wr_sel;
    logic [3:0]        rd_idx;
    logic [IW-1:0]     rd_sel;
    logic              rd_ok;
    logic [77:0]       rd_word;
    logic [3:0]        probe_low;

    logic unused_bits;
    assign unused_bits = ^{bus.cp0_index[31:4], bus.cp0_entryhi[12:8],
                           bus.cp0_entrylo0[31:26], bus.cp0_entrylo1[31:26]};

    // Lowest set bit of a match vector; 0 when nothing matches
    function automatic logic [3:0] lowest(input logic [TLBNUM-1:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    assign is_idle   = (state_q == IDLE);
    assign accept_wi = is_idle && bus.cmd_valid && (bus.cmd_op == 2'b11);
    assign accept_r  = is_idle && bus.cmd_valid && (bus.cmd_op == 2'b10);
    assign accept_p  = is_idle && bus.cmd_valid && (bus.cmd_op == 2'b01);

`ifdef TLB_TLBWR_EN
    logic [3:0] random_q;

    // Random register counts down every cycle and wraps to the top entry
    always_ff @(posedge cp0_clk) begin
        if (reset) begin
            random_q <= 4'(TLBNUM - 1);
        end else if (random_q == 4'd0) begin
            random_q <= 4'(TLBNUM - 1);
        end else begin
            random_q <= random_q - 4'd1;
        end
    end

    assign random_index = random_q;
    assign accept_wr    = is_idle && bus.cmd_valid && (bus.cmd_op == 2'b00);
    assign wr_idx       = accept_wr ? random_q : bus.cp0_index[3:0];
`else
    assign accept_wr    = 1'b0;
    assign wr_idx       = bus.cp0_index[3:0];
`endif

    assign wr_en  = accept_wi || accept_wr;
    assign wr_ok  = ({1'b0, wr_idx} < NUM5);
    assign wr_sel = wr_idx[IW-1:0];
    assign rd_idx = bus.cp0_index[3:0];
    assign rd_ok  = ({1'b0, rd_idx} < NUM5);
    assign rd_sel = rd_idx[IW-1:0];

    // Entry array: cleared on reset, written on an accepted TLBWI/TLBWR with an in-range index
    always_ff @(posedge cp0_clk) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) begin
                vpn2_q[i] <= '0;
                asid_q[i] <= '0;
                pfn0_q[i] <= '0;
                c0_q[i]   <= '0;
                pfn1_q[i] <= '0;
                c1_q[i]   <= '0;
            end
            g_q  <= '0;
            d0_q <= '0;
            v0_q <= '0;
            d1_q <= '0;
            v1_q <= '0;
        end else if (wr_en && wr_ok) begin
            vpn2_q[wr_sel] <= bus.cp0_entryhi[31:13];
            asid_q[wr_sel] <= bus.cp0_entryhi[7:0];
            g_q[wr_sel]    <= bus.cp0_entrylo0[0] & bus.cp0_entrylo1[0];
            pfn0_q[wr_sel] <= bus.cp0_entrylo0[25:6];
            c0_q[wr_sel]   <= bus.cp0_entrylo0[5:3];
            d0_q[wr_sel]   <= bus.cp0_entrylo0[2];
            v0_q[wr_sel]   <= bus.cp0_entrylo0[1];
            pfn1_q[wr_sel] <= bus.cp0_entrylo1[25:6];
            c1_q[wr_sel]   <= bus.cp0_entrylo1[5:3];
            d1_q[wr_sel]   <= bus.cp0_entrylo1[2];
            v1_q[wr_sel]   <= bus.cp0_entrylo1[1];
        end
    end

    // Packed copy of the entry addressed by CP0 Index, in TLB_rdata layout
    always_comb begin
        rd_word = {vpn2_q[rd_sel], asid_q[rd_sel], g_q[rd_sel],
                   pfn0_q[rd_sel], c0_q[rd_sel], d0_q[rd_sel], v0_q[rd_sel],
                   pfn1_q[rd_sel], c1_q[rd_sel], d1_q[rd_sel], v1_q[rd_sel]};
    end

    // Probe match vector against the latched EntryHi key; V bits play no part
    always_comb begin
        probe_hit = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            probe_hit[i] = (vpn2_q[i] == key_vpn2_q) && (g_q[i] || (asid_q[i] == key_asid_q));
        end
    end

    assign probe_low = lowest(match_q);

    // Command datapath: probe key/match, read capture, write-done pulse and held probe results
    always_ff @(posedge cp0_clk) begin
        if (reset) begin
            key_vpn2_q  <= '0;
            key_asid_q  <= '0;
            match_q     <= '0;
            rdata_q     <= '0;
            wr_done_q   <= 1'b0;
            wp_hold_q   <= 1'b0;
            widx_hold_q <= '0;
        end else begin
            wr_done_q <= wr_en;
            if (accept_p) begin
                key_vpn2_q <= bus.cp0_entryhi[31:13];
                key_asid_q <= bus.cp0_entryhi[7:0];
            end
            if (state_q == PROBE) begin
                match_q <= probe_hit;
            end
            if (state_q == P_RESP) begin
                wp_hold_q   <= ~|match_q;
                widx_hold_q <= probe_low;
            end
            if (accept_r) begin
                rdata_q <= rd_ok ? rd_word : '0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge cp0_clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and result outputs; probe results hold their last value outside P_RESP
    always_comb begin
        state_d               = state_q;
        bus.cmd_ready         = 1'b0;
        bus.cmd_done          = wr_done_q;
        bus.is_TLBR           = 1'b0;
        bus.is_TLBP           = 1'b0;
        bus.TLB_rdata         = rdata_q;
        bus.index_write_p     = wp_hold_q;
        bus.index_write_index = widx_hold_q;
        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (accept_r) begin
                    state_d = R_RESP;
                end else if (accept_p) begin
                    state_d = PROBE;
                end
            end
            PROBE: begin
                state_d = P_RESP;
            end
            P_RESP: begin
                bus.is_TLBP           = 1'b1;
                bus.cmd_done          = 1'b1;
                bus.index_write_p     = ~|match_q;
                bus.index_write_index = probe_low;
                state_d               = IDLE;
            end
            R_RESP: begin
                bus.is_TLBR  = 1'b1;
                bus.cmd_done = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    logic [1:0][18:0] lk_vpn2;
    logic [1:0]       lk_odd;
    logic [1:0][7:0]  lk_asid;

    assign lk_vpn2 = {s1_vpn2, s0_vpn2};
    assign lk_odd  = {s1_odd, s0_odd};
    assign lk_asid = {s1_asid, s0_asid};

    for (genvar p = 0; p < 2; p++) begin : g_lookup
        logic [TLBNUM-1:0] hit;
        logic [3:0]        low;
        logic [IW-1:0]     sel;
        logic              found;
        logic [19:0]       pfn;
        logic [2:0]        c;
        logic              d;
        logic              v;

        // Per-entry hit for this lookup port, same rule as TLBP
        always_comb begin
            hit = '0;
            for (int i = 0; i < TLBNUM; i++) begin
                hit[i] = (vpn2_q[i] == lk_vpn2[p]) && (g_q[i] || (asid_q[i] == lk_asid[p]));
            end
        end

        assign low = lowest(hit);
        assign sel = low[IW-1:0];

        // Page select from the lowest-index hit; everything reads 0 on a miss
        always_comb begin
            found = 1'b0;
            pfn   = '0;
            c     = '0;
            d     = 1'b0;
            v     = 1'b0;
            if (|hit) begin
                found = 1'b1;
                if (lk_odd[p]) begin
                    pfn = pfn1_q[sel];
                    c   = c1_q[sel];
                    d   = d1_q[sel];
                    v   = v1_q[sel];
                end else begin
                    pfn = pfn0_q[sel];
                    c   = c0_q[sel];
                    d   = d0_q[sel];
                    v   = v0_q[sel];
                end
            end
        end
    end

    assign s0_found = g_lookup[0].found;
    assign s0_pfn   = g_lookup[0].pfn;
    assign s0_c     = g_lookup[0].c;
    assign s0_d     = g_lookup[0].d;
    assign s0_v     = g_lookup[0].v;
    assign s1_found = g_lookup[1].found;
    assign s1_pfn   = g_lookup[1].pfn;
    assign s1_c     = g_lookup[1].c;
    assign s1_d     = g_lookup[1].d;
    assign s1_v     = g_lookup[1].v;

endmodule

// File: tb/tb_tlb_cmd_unit.sv
// Testbench for tlb_cmd_unit: directed commands with hand-computed results.
// Command results go through a scoreboard queue checked by a monitor on cmd_done;
// lookup ports and held outputs are checked directly. A second instance with
// TLBNUM = 8 covers out-of-range indices.
module tb_tlb_cmd_unit;

    logic cp0_clk = 1'b0;
    logic reset;

    always #5 cp0_clk = ~cp0_clk;

    tlb_cmd_unit_if bus ();
    tlb_cmd_unit_if bus8 ();

    logic [18:0] s0_vpn2, s1_vpn2, l8_vpn2;
    logic        s0_odd, s1_odd, l8_odd;
    logic [7:0]  s0_asid, s1_asid, l8_asid;
    logic        s0_found, s1_found, l8_found, u8_found;
    logic [19:0] s0_pfn, s1_pfn, l8_pfn, u8_pfn;
    logic [2:0]  s0_c, s1_c, l8_c, u8_c;
    logic        s0_d, s1_d, l8_d, u8_d;
    logic        s0_v, s1_v, l8_v, u8_v;
`ifdef TLB_TLBWR_EN
    logic [3:0]  random_index, random_index8;
`endif

    tlb_cmd_unit #(.TLBNUM(16)) dut (
        .cp0_clk(cp0_clk), .reset(reset), .bus(bus),
        .s0_vpn2(s0_vpn2), .s0_odd(s0_odd), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vpn2(s1_vpn2), .s1_odd(s1_odd), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v)
`ifdef TLB_TLBWR_EN
        , .random_index(random_index)
`endif
    );

    tlb_cmd_unit #(.TLBNUM(8)) dut8 (
        .cp0_clk(cp0_clk), .reset(reset), .bus(bus8),
        .s0_vpn2(l8_vpn2), .s0_odd(l8_odd), .s0_asid(l8_asid),
        .s0_found(l8_found), .s0_pfn(l8_pfn), .s0_c(l8_c), .s0_d(l8_d), .s0_v(l8_v),
        .s1_vpn2(19'h0), .s1_odd(1'b0), .s1_asid(8'h0),
        .s1_found(u8_found), .s1_pfn(u8_pfn), .s1_c(u8_c), .s1_d(u8_d), .s1_v(u8_v)
`ifdef TLB_TLBWR_EN
        , .random_index(random_index8)
`endif
    );

    typedef struct {
        int          kind;   // 0 write, 1 read, 2 probe
        logic [77:0] rdata;
        logic        wp;
        logic [3:0]  widx;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   cycle  = 0;
    int   errors = 0;
    int   checks = 0;
    int   waitsA, waitsB;
    logic wrFound;

    localparam logic [77:0] E3 = {19'h091A2, 8'h05, 1'b0, 20'h00044, 3'd2, 1'b1, 1'b1,
                                  20'h00084, 3'd2, 1'b1, 1'b1};
    localparam logic [77:0] E9 = {19'h00001, 8'h22, 1'b1, 20'h00005, 3'd0, 1'b1, 1'b1,
                                  20'h00006, 3'd0, 1'b0, 1'b0};

    always @(posedge cp0_clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [77:0] act, input logic [77:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every cmd_done pops one expected result; stray pulses are errors
    always @(negedge cp0_clk) begin
        if (reset === 1'b0) begin
            if (bus.cmd_done === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 78'(bus.cmd_done), 78'd0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("done_cycle", 78'(cycle), 78'(monExp.cyc));
                    checkOutput("is_TLBR", 78'(bus.is_TLBR), 78'(monExp.kind == 1));
                    checkOutput("is_TLBP", 78'(bus.is_TLBP), 78'(monExp.kind == 2));
                    if (monExp.kind == 1) begin
                        checkOutput("TLB_rdata", bus.TLB_rdata, monExp.rdata);
                    end
                    if (monExp.kind == 2) begin
                        checkOutput("index_write_p", 78'(bus.index_write_p), 78'(monExp.wp));
                        checkOutput("index_write_index", 78'(bus.index_write_index), 78'(monExp.widx));
                    end
                end
            end else if (bus.is_TLBR === 1'b1 || bus.is_TLBP === 1'b1) begin
                checkOutput("stray_result_pulse", 78'({bus.is_TLBR, bus.is_TLBP}), 78'd0);
            end
        end
    end

    // Present one command, wait (bounded) for cmd_ready, queue the expectation, return at posedge+1
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] hi,
                                 input logic [31:0] lo0, input logic [31:0] lo1, input int kind,
                                 input logic [77:0] rdata, input logic wp, input logic [3:0] widx,
                                 input int lat, input logic keepValid,
                                 output int waits, output logic foundAtAccept);
        exp_t e;
        bus.cmd_valid    = 1'b1;
        bus.cmd_op       = op;
        bus.cp0_index    = idx;
        bus.cp0_entryhi  = hi;
        bus.cp0_entrylo0 = lo0;
        bus.cp0_entrylo1 = lo1;
        waits            = 0;
        foundAtAccept    = 1'b0;
        @(negedge cp0_clk);
        while (bus.cmd_ready !== 1'b1 && waits < 50) begin
            waits++;
            @(negedge cp0_clk);
        end
        if (bus.cmd_ready !== 1'b1) begin
            checkOutput("ready_timeout", 78'(bus.cmd_ready), 78'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        foundAtAccept = s0_found;
        e.kind  = kind;
        e.rdata = rdata;
        e.wp    = wp;
        e.widx  = widx;
        e.cyc   = cycle + lat;
        if (lat > 0) expQ.push_back(e);
        @(posedge cp0_clk);
        #1;
        if (!keepValid) bus.cmd_valid = 1'b0;
    endtask

    task automatic doWrite(input logic [31:0] idx, input logic [31:0] hi, input logic [31:0] lo0,
                           input logic [31:0] lo1);
        int w;
        logic f;
        applyStimulus(2'b11, idx, hi, lo0, lo1, 0, '0, 1'b0, 4'd0, 1, 1'b0, w, f);
    endtask

    task automatic doRead(input logic [31:0] idx, input logic [77:0] rdata);
        int w;
        logic f;
        applyStimulus(2'b10, idx, 32'h0, 32'h0, 32'h0, 1, rdata, 1'b0, 4'd0, 1, 1'b0, w, f);
    endtask

    task automatic doProbe(input logic [31:0] hi, input logic wp, input logic [3:0] widx);
        int w;
        logic f;
        applyStimulus(2'b01, 32'h0, hi, 32'h0, 32'h0, 2, '0, wp, widx, 2, 1'b0, w, f);
    endtask

    // Let outstanding results arrive (bounded); anything still queued is an error
    task automatic waitDrain();
        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge cp0_clk);
        if (expQ.size() != 0) begin
            checkOutput("result_timeout", 78'(expQ.size()), 78'd0);
            expQ.delete();
        end
        @(posedge cp0_clk);
        #1;
    endtask

    // One command on the TLBNUM=8 instance; returns at the negedge of the result cycle
    task automatic run8(input logic [1:0] op, input logic [31:0] idx);
        bus8.cmd_valid = 1'b1;
        bus8.cmd_op    = op;
        bus8.cp0_index = idx;
        @(posedge cp0_clk);
        #1;
        bus8.cmd_valid = 1'b0;
        @(negedge cp0_clk);
    endtask

    initial begin
        reset             = 1'b1;
        bus.cmd_valid     = 1'b0;
        bus.cmd_op        = 2'b00;
        bus.cp0_index     = '0;
        bus.cp0_entryhi   = '0;
        bus.cp0_entrylo0  = '0;
        bus.cp0_entrylo1  = '0;
        bus8.cmd_valid    = 1'b0;
        bus8.cmd_op       = 2'b00;
        bus8.cp0_index    = '0;
        bus8.cp0_entryhi  = 32'h12344005;
        bus8.cp0_entrylo0 = 32'h00001116;
        bus8.cp0_entrylo1 = 32'h00002117;
        s0_vpn2 = 19'h091A2; s0_odd = 1'b1; s0_asid = 8'h05;
        s1_vpn2 = 19'h00001; s1_odd = 1'b0; s1_asid = 8'h77;
        l8_vpn2 = 19'h091A2; l8_odd = 1'b1; l8_asid = 8'h05;
        repeat (3) @(posedge cp0_clk);
        #1;
        reset = 1'b0;

        @(negedge cp0_clk);
        checkOutput("reset_cmd_ready", 78'(bus.cmd_ready), 78'd1);
        checkOutput("reset_cmd_done", 78'(bus.cmd_done), 78'd0);
        checkOutput("reset_pulses", 78'({bus.is_TLBR, bus.is_TLBP}), 78'd0);
        checkOutput("reset_wp", 78'(bus.index_write_p), 78'd0);
        checkOutput("reset_widx", 78'(bus.index_write_index), 78'd0);
        checkOutput("reset_rdata", bus.TLB_rdata, 78'd0);
        checkOutput("reset_s0_found", 78'(s0_found), 78'd0);
        @(posedge cp0_clk);
        #1;

        $display("[TB] TLBWI entry 3, lookup visibility, TLBR and TLBP");
        applyStimulus(2'b11, 32'd3, 32'h12344005, 32'h00001116, 32'h00002117, 0, '0, 1'b0, 4'd0,
                      1, 1'b0, waitsA, wrFound);
        checkOutput("lookup_in_write_cycle", 78'(wrFound), 78'd0);
        @(negedge cp0_clk);
        checkOutput("lookup_after_write", 78'({s0_found, s0_pfn, s0_c, s0_d, s0_v}),
                    78'({1'b1, 20'h00084, 3'd2, 1'b1, 1'b1}));
        s0_odd = 1'b0;
        #1;
        checkOutput("lookup_even_page", 78'({s0_found, s0_pfn, s0_c, s0_d, s0_v}),
                    78'({1'b1, 20'h00044, 3'd2, 1'b1, 1'b1}));
        s0_asid = 8'h06;
        #1;
        checkOutput("lookup_asid_miss", 78'({s0_found, s0_pfn, s0_c, s0_d, s0_v}), 78'd0);
        s0_asid = 8'h05;
        s0_odd  = 1'b1;
        @(posedge cp0_clk);
        #1;
        doRead(32'd3, E3);
        doProbe(32'h12344005, 1'b0, 4'd3);
        doProbe(32'h12344006, 1'b1, 4'd0);
        waitDrain();
        checkOutput("probe_result_held", 78'({bus.index_write_p, bus.index_write_index}), 78'h10);
        checkOutput("rdata_held", bus.TLB_rdata, E3);

        $display("[TB] global entries 2 and 9 with the same VPN2");
        doWrite(32'd2, 32'h00002011, 32'h00000043, 32'h00000081);
        doWrite(32'd9, 32'h00002022, 32'h00000147, 32'h00000181);
        doProbe(32'h000020AA, 1'b0, 4'd2);
        doRead(32'd9, E9);
        waitDrain();
        @(negedge cp0_clk);
        checkOutput("global_lookup_even", 78'({s1_found, s1_pfn, s1_c, s1_d, s1_v}),
                    78'({1'b1, 20'h00001, 3'd0, 1'b0, 1'b1}));
        s1_odd = 1'b1;
        #1;
        checkOutput("global_lookup_odd_invalid", 78'({s1_found, s1_pfn, s1_c, s1_d, s1_v}),
                    78'({1'b1, 20'h00002, 3'd0, 1'b0, 1'b0}));
        s1_vpn2 = 19'h00002;
        #1;
        checkOutput("lookup_vpn_miss", 78'({s1_found, s1_pfn, s1_c, s1_d, s1_v}), 78'd0);
        s1_vpn2 = 19'h00001;
        @(posedge cp0_clk);
        #1;

        $display("[TB] cmd_valid held through a probe");
        applyStimulus(2'b01, 32'h0, 32'h12344005, 32'h0, 32'h0, 2, '0, 1'b0, 4'd3, 2, 1'b1,
                      waitsA, wrFound);
        applyStimulus(2'b10, 32'd3, 32'h0, 32'h0, 32'h0, 1, E3, 1'b0, 4'd0, 1, 1'b0,
                      waitsB, wrFound);
        checkOutput("held_cmd_wait_cycles", 78'(waitsB), 78'd2);
        waitDrain();

`ifndef TLB_TLBWR_EN
        $display("[TB] reserved op 00 is ignored");
        applyStimulus(2'b00, 32'd4, 32'h12344005, 32'h1116, 32'h2117, 0, '0, 1'b0, 4'd0, 0, 1'b0,
                      waitsA, wrFound);
        waitDrain();
        @(negedge cp0_clk);
        checkOutput("reserved_stays_idle", 78'(bus.cmd_ready), 78'd1);
        @(posedge cp0_clk);
        #1;
`endif

        $display("[TB] reset during PROBE");
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = 2'b01;
        bus.cp0_entryhi = 32'h12344005;
        @(negedge cp0_clk);
        checkOutput("probe_accept_ready", 78'(bus.cmd_ready), 78'd1);
        @(posedge cp0_clk);
        #1;
        bus.cmd_valid = 1'b0;
        reset         = 1'b1;
        @(posedge cp0_clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge cp0_clk);
        checkOutput("post_reset_ready", 78'(bus.cmd_ready), 78'd1);
        checkOutput("post_reset_s0_miss", 78'(s0_found), 78'd0);
        checkOutput("post_reset_s1_miss", 78'(s1_found), 78'd0);
        checkOutput("post_reset_probe_out", 78'({bus.index_write_p, bus.index_write_index}), 78'd0);
        @(posedge cp0_clk);
        #1;
        doRead(32'd3, 78'd0);
        waitDrain();

        $display("[TB] TLBNUM=8 instance, out-of-range index");
        run8(2'b11, 32'd15);
        checkOutput("n8_wi15_done", 78'(bus8.cmd_done), 78'd1);
        @(negedge cp0_clk);
        checkOutput("n8_wi15_no_write", 78'(l8_found), 78'd0);
        @(posedge cp0_clk);
        #1;
        run8(2'b11, 32'd7);
        @(negedge cp0_clk);
        checkOutput("n8_wi7_lookup", 78'({l8_found, l8_pfn}), 78'({1'b1, 20'h00084}));
        @(posedge cp0_clk);
        #1;
        run8(2'b10, 32'd7);
        checkOutput("n8_r7_pulse", 78'(bus8.is_TLBR), 78'd1);
        checkOutput("n8_r7_rdata", bus8.TLB_rdata, E3);
        @(posedge cp0_clk);
        #1;
        run8(2'b10, 32'd15);
        checkOutput("n8_r15_pulse", 78'(bus8.is_TLBR), 78'd1);
        checkOutput("n8_r15_rdata", bus8.TLB_rdata, 78'd0);
        @(posedge cp0_clk);
        #1;

        waitDrain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlb_cmd_unit.md
Name: tlb_cmd_unit

Overview:
- 16-entry, fully associative MIPS TLB. Serves as the responder to the CP0 TLB interface.
- Consumes CP0 Index/EntryHi/EntryLo0/EntryLo1 and executes TLBWI/TLBR/TLBP commands from WB through a small FSM.
- Returns the is_TLBR/TLB_rdata and is_TLBP/index_write_p/index_write_index pulses that CP0 latches.
- Two combinational lookup ports serve instruction fetch and data access.

Parameters:
- TLBNUM, 16, number of entries; power of two, 2..16; index fields stay 4 bits wide.

Ports:
- cp0_clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command request from WB
- cmd_op  in  2  01 TLBP, 10 TLBR, 11 TLBWI, 00 reserved (see optional feature)
- cmd_ready  out  1  unit idle, can accept a command
- cmd_done  out  1  one-cycle pulse on command completion
- cp0_index  in  32  CP0 Index; bits [3:0] used
- cp0_entryhi  in  32  VPN2 [31:13], ASID [7:0]
- cp0_entrylo0  in  32  PFN [25:6], C [5:3], D [2], V [1], G [0]
- cp0_entrylo1  in  32  same layout as entrylo0
- is_TLBR  out  1  TLBR result valid pulse to CP0
- TLB_rdata  out  78  {VPN2[18:0], ASID[7:0], G, PFN0[19:0], C0[2:0], D0, V0, PFN1[19:0], C1[2:0], D1, V1}
- is_TLBP  out  1  TLBP result valid pulse to CP0
- index_write_p  out  1  1 = probe miss
- index_write_index  out  4  matched entry index
- sN_vpn2 (N = 0, 1)  in  19  lookup VPN2
- sN_odd  in  1  vaddr[12]
- sN_asid  in  8  lookup ASID
- sN_found  out  1  hit on the selected page
- sN_pfn  out  20  PFN of the selected page
- sN_c  out  3  cache attribute of the selected page
- sN_d  out  1  dirty bit of the selected page
- sN_v  out  1  valid bit of the selected page

Behaviour:
- Reset:
  - All entries cleared: every field 0, so V0 = V1 = 0.
  - FSM returns to IDLE.
  - cmd_ready = 1; cmd_done, is_TLBR, is_TLBP, index_write_p = 0; index_write_index = 0; TLB_rdata = 0.
  - Reset in any state (mid-probe or mid-read) aborts the command; no result pulse is emitted.
- FSM states: IDLE, PROBE, P_RESP, R_RESP.
  - cmd_ready = 1 only in IDLE. Commands presented outside IDLE are not accepted; WB must hold cmd_valid until cmd_ready.
- TLBWI (accepted in IDLE):
  - Entry cp0_index[3:0] is written at the accepting edge.
  - Fields written: VPN2, ASID, G = entrylo0[0] & entrylo1[0], PFN0/C0/D0/V0, PFN1/C1/D1/V1.
  - cmd_done pulses the following cycle; state stays IDLE.
  - Index >= TLBNUM: no write, cmd_done still pulses.
- TLBR:
  - IDLE->R_RESP; index latched at acceptance.
  - In R_RESP: is_TLBR = 1, cmd_done = 1, TLB_rdata = registered copy of the entry; then ->IDLE.
  - Index >= TLBNUM returns TLB_rdata = 0.
  - Latency: result in the cycle after acceptance.
- TLBP:
  - IDLE->PROBE latches the EntryHi VPN2/ASID key.
  - PROBE registers the match vector: match[i] = (VPN2 equal) && (G[i] || ASID equal). V bits are ignored. Then ->P_RESP.
  - P_RESP: is_TLBP = 1, cmd_done = 1, index_write_p = ~|match, index_write_index = lowest matching index (0 on miss); then ->IDLE.
  - Latency: result 2 cycles after acceptance.
- Result outputs hold their last values between pulses. Only the pulse signals return to 0.
- Lookup ports:
  - Purely combinational from the current array state.
  - Hit per entry uses the same match rule as TLBP. Page select is sN_odd (1 = page 1).
  - sN_found = any hit; data comes from the lowest-index hit. sN_v is the selected page V; a hit with V = 0 reports found = 1, v = 0.
  - On no hit: all sN_* outputs are 0.
  - A TLBWI is visible to lookups from the cycle after the write edge.
- Reserved op 00 with cmd_valid in IDLE: no state change, no cmd_done (unless the optional feature is enabled).

Optional Feature:
- Macro TLB_TLBWR_EN.
- Defined:
  - Adds a 4-bit random register, reset to TLBNUM-1, decrementing every cycle and wrapping 0 -> TLBNUM-1.
  - cmd_op 00 = TLBWR: writes the entry at the current random value at the accepting edge, same fields as TLBWI; cmd_done pulses the next cycle.
  - Output random_index [3:0] exposes the register.
- Undefined: op 00 is ignored as above and random_index does not exist.

Test Plan:
- TLBWI, index 3, EntryHi 0x12344005, Lo0 0x00001116, Lo1 0x00002117 -> cmd_done next cycle. Then TLBR index 3 -> is_TLBR, TLB_rdata VPN2 = 0x091A2, ASID = 0x05, G = 0, PFN0 = 0x00044, C0 = 2, D0 = 1, V0 = 1, PFN1 = 0x00084, C1 = 2, D1 = 1, V1 = 1.
- TLBP with EntryHi 0x12344005 after the write above -> is_TLBP 2 cycles after acceptance, index_write_p = 0, index_write_index = 3. TLBP with ASID 0x06 -> index_write_p = 1, index_write_index = 0.
- Lookup s0_vpn2 = 0x091A2, s0_odd = 1, s0_asid = 0x05 the cycle after the write -> found = 1, pfn = 0x00084, v = 1. Same lookup issued in the write cycle itself -> found = 0.
- Write entries 2 and 9 with identical VPN2, both G = 1 -> TLBP and lookups with any ASID report index 2.
- Hold cmd_valid = 1 during a TLBP -> cmd_ready = 0 in PROBE/P_RESP; the second command is accepted only in IDLE. TLBR of index 15 with TLBNUM = 8 -> TLB_rdata = 0.
- Assert reset during PROBE -> no is_TLBP pulse, cmd_ready = 1, all lookups miss, TLBR returns 0.
